// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the memory copy/fill engine.
//   - default geometry (word-address width, bytes per word)
//   - FSM state encoding used by the top-level controller
package mem_copy_engine_pkg;

    localparam int DEF_ADDR_WIDTH      = 6;
    localparam int DEF_DATA_SIZE_BYTES = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR      = 3'd3,
        S_FINISH  = 3'd4
    } state_e;

endpackage

// File: rtl/mem_copy_addr_gen.sv
// Address generator for mem_copy_engine.
// Holds the word offset and remaining-count registers, picks the copy
// direction so that overlapping copies behave like memmove, and checks the
// command range against the memory size.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   init_i          load offset/count/direction from the command
//   step_i          one word written: decrement count, advance offset
//   fill_i          command is a fill (source range and direction ignored)
//   src_i, dst_i    first source / destination word
//   len_i           word count, 0..2^ADDR_WIDTH
//   ok_o            command is within range and non-empty
//   last_o          the current word is the final one
//   rd_addr_o       src + offset
//   wr_addr_o       dst + offset
import mem_copy_engine_pkg::*;

module mem_copy_addr_gen #(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_i,
    input  logic                  step_i,
    input  logic                  fill_i,
    input  logic [ADDR_WIDTH-1:0] src_i,
    input  logic [ADDR_WIDTH-1:0] dst_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    output logic                  ok_o,
    output logic                  last_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o
);

    // Two extra bits so src+len can reach 2^(ADDR_WIDTH+1)-1 without wrapping.
    localparam logic [ADDR_WIDTH+1:0] MEM_WORDS = (ADDR_WIDTH+2)'(1) << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] off_q;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic                  bwd_q;

    logic [ADDR_WIDTH+1:0] src_end;
    logic [ADDR_WIDTH+1:0] dst_end;
    logic                  bwd;

    assign src_end = {2'b00, src_i} + {1'b0, len_i};
    assign dst_end = {2'b00, dst_i} + {1'b0, len_i};

    // Source range only matters for a copy.
    assign ok_o = (len_i != '0) && (dst_end <= MEM_WORDS) &&
                  (fill_i || (src_end <= MEM_WORDS));

    // Destination starts inside the source window: walk from the top down so
    // no source word is overwritten before it has been read.
    assign bwd = !fill_i && (dst_i > src_i) && ({2'b00, dst_i} < src_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            off_q <= '0;
            cnt_q <= '0;
            bwd_q <= 1'b0;
        end else if (init_i) begin
            off_q <= bwd ? ADDR_WIDTH'(len_i - (ADDR_WIDTH+1)'(1)) : '0;
            cnt_q <= len_i;
            bwd_q <= bwd;
        end else if (step_i) begin
            cnt_q <= cnt_q - (ADDR_WIDTH+1)'(1);
            off_q <= bwd_q ? off_q - ADDR_WIDTH'(1) : off_q + ADDR_WIDTH'(1);
        end
    end

    assign last_o    = (cnt_q == (ADDR_WIDTH+1)'(1));
    assign rd_addr_o = src_i + off_q;
    assign wr_addr_o = dst_i + off_q;

endmodule

// File: rtl/mem_copy_engine.sv
// Memory copy / fill engine.
// A start strobe in IDLE latches a command; the next cycle it is either
// rejected (err pulse) or run: a copy reads one word, waits for rd_valid,
// writes it; a fill writes the pattern once per cycle. done pulses from
// FINISH after the last write.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, fill                   command strobe and mode (1 = fill)
//   src_addr, dst_addr, len       command geometry
//   pattern                       fill value
//   busy, done, err               status
//   rd_en, rd_addr, rd_data, rd_valid   RAM read port
//   wr_en, wr_addr, wr_data             RAM write port
import mem_copy_engine_pkg::*;

module mem_copy_engine #(
    parameter  int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter  int DATA_SIZE_BYTES = DEF_DATA_SIZE_BYTES,
    localparam int DATA_WIDTH      = DATA_SIZE_BYTES * 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  fill,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic [DATA_WIDTH-1:0] pattern,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_valid,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data
);

    state_e                state_q, state_d;
    logic                  cmd_vld_q;
    logic                  fill_q;
    logic [ADDR_WIDTH-1:0] src_q, dst_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [DATA_WIDTH-1:0] pattern_q;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;

    logic init, step, ok, last;

    // Command latch: cmd_vld_q marks the single evaluation cycle that follows
    // an accepted strobe. Starts during that cycle are not taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_vld_q <= 1'b0;
            fill_q    <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            pattern_q <= '0;
        end else begin
            cmd_vld_q <= 1'b0;
            if (state_q == S_IDLE && !cmd_vld_q && start) begin
                cmd_vld_q <= 1'b1;
                fill_q    <= fill;
                src_q     <= src_addr;
                dst_q     <= dst_addr;
                len_q     <= len;
                pattern_q <= pattern;
            end
        end
    end

    mem_copy_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .init_i   (init),
        .step_i   (step),
        .fill_i   (fill_q),
        .src_i    (src_q),
        .dst_i    (dst_q),
        .len_i    (len_q),
        .ok_o     (ok),
        .last_o   (last),
        .rd_addr_o(rd_addr),
        .wr_addr_o(wr_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        err_d   = 1'b0;
        init    = 1'b0;
        step    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_vld_q) begin
                    if (ok) begin
                        init    = 1'b1;
                        state_d = fill_q ? S_WR : S_RD_REQ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RD_REQ: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (rd_valid) begin
                    data_d  = rd_data;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                step = 1'b1;
                if (last)        state_d = S_FINISH;
                else if (fill_q) state_d = S_WR;
                else             state_d = S_RD_REQ;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobes decode straight from the state register, so a reset edge
    // silences the RAM port in the very next cycle.
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_FINISH);
    assign err     = err_q;
    assign rd_en   = (state_q == S_RD_REQ);
    assign wr_en   = (state_q == S_WR);
    assign wr_data = fill_q ? pattern_q : data_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
module tb_mem_copy_engine;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int NW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          fill = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW:0]   len = '0;
    logic [DW-1:0] pattern = '0;
    logic          busy, done, err, rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] rd_data = '0;
    logic          rd_valid = 1'b0;
    logic [DW-1:0] wr_data;

    mem_copy_engine #(.ADDR_WIDTH(AW), .DATA_SIZE_BYTES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .fill(fill),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .pattern(pattern),
        .busy(busy), .done(done), .err(err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // RAM model: read data returns lat cycles after rd_en.
    logic [DW-1:0] mem [NW];
    logic [DW-1:0] ref_mem [NW];
    logic          ram_init = 1'b0;
    int            lat = 1;
    logic          pend = 1'b0;
    int            pcnt = 0;
    logic [AW-1:0] paddr = '0;

    always @(posedge clk) begin
        rd_valid <= 1'b0;
        if (ram_init) begin
            for (int i = 0; i < NW; i++) mem[i] <= DW'(i);
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (pend && pcnt == 0) begin
            rd_valid <= 1'b1;
            rd_data  <= mem[paddr];
            pend     <= 1'b0;
        end else if (pend) begin
            pcnt <= pcnt - 1;
        end
        if (rd_en) begin
            if (lat == 1) begin
                rd_valid <= 1'b1;
                rd_data  <= mem[rd_addr];
            end else begin
                pend  <= 1'b1;
                pcnt  <= lat - 2;
                paddr <= rd_addr;
            end
        end
    end

    // Bus monitor, sampled mid-cycle.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0, both_cnt = 0;
    int done_cyc = 0;
    int wr_addr_log [$];
    int wr_cyc_log [$];

    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            wr_addr_log.push_back(int'(wr_addr));
            wr_cyc_log.push_back(cyc);
        end
        if (rd_en) rd_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err)  err_cnt++;
        if (busy) busy_cnt++;
        if (rd_en && wr_en) both_cnt++;
    end

    task automatic init_mem();
        @(negedge clk);
        ram_init = 1'b1;
        @(negedge clk);
        ram_init = 1'b0;
        for (int i = 0; i < NW; i++) ref_mem[i] = DW'(i);
    endtask

    task automatic chk_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < NW; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk(tag, bad, 0);
    endtask

    // order: 0 = don't care, 1 = ascending, 2 = descending write addresses
    task automatic run_cmd(input string tag, input logic f, input int s, input int d,
                           input int l, input logic [DW-1:0] pat, input int order);
        int w0 = wr_cnt, r0 = rd_cnt, d0 = done_cnt, e0 = err_cnt, b0 = busy_cnt, x0 = both_cnt;
        int q0 = wr_addr_log.size();
        int n = 0, bad = 0, step;
        bit rej = (l == 0) || (d + l > NW) || (!f && s + l > NW);
        logic [DW-1:0] tmp [NW];

        if (!rej) begin
            for (int k = 0; k < l; k++) tmp[k] = f ? pat : ref_mem[s + k];
            for (int k = 0; k < l; k++) ref_mem[d + k] = tmp[k];
        end

        @(negedge clk);
        start = 1'b1; fill = f; src_addr = AW'(s); dst_addr = AW'(d);
        len = (AW+1)'(l); pattern = pat;
        @(negedge clk);
        // scramble the inputs: the command must have been latched
        start = 1'b0; fill = $urandom_range(0, 1); src_addr = AW'($urandom);
        dst_addr = AW'($urandom); len = (AW+1)'($urandom); pattern = $urandom;
        while (done_cnt == d0 && err_cnt == e0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk({tag, ".timeout"}, (n < 3000), 1);
        repeat (3) @(posedge clk);

        chk({tag, ".err"},  err_cnt - e0, rej ? 1 : 0);
        chk({tag, ".done"}, done_cnt - d0, rej ? 0 : 1);
        chk({tag, ".wr"},   wr_cnt - w0, rej ? 0 : l);
        chk({tag, ".rd"},   rd_cnt - r0, (rej || f) ? 0 : l);
        chk({tag, ".busy"}, busy_cnt - b0, rej ? 0 : (f ? l + 1 : l * (2 + lat) + 1));
        chk({tag, ".rdwr_overlap"}, both_cnt - x0, 0);
        chk_mem({tag, ".mem"});

        if (!rej) begin
            step = f ? 1 : 2 + lat;
            for (int k = q0 + 1; k < wr_cyc_log.size(); k++)
                if (wr_cyc_log[k] - wr_cyc_log[k-1] != step) bad++;
            chk({tag, ".spacing"}, bad, 0);
            chk({tag, ".done_lat"}, done_cyc - wr_cyc_log[wr_cyc_log.size()-1], 1);
            bad = 0;
            if (order != 0) begin
                for (int k = 0; k < l; k++)
                    if (wr_addr_log[q0 + k] != ((order == 1) ? d + k : d + l - 1 - k)) bad++;
                chk({tag, ".order"}, bad, 0);
            end
        end
    endtask

    initial begin
        int r0, w0, d0, e0, n;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst.outs", {busy, done, err, rd_en, wr_en, rd_addr, wr_addr, wr_data}, 0);
        @(negedge clk);
        rst = 1'b0;

        // forward copy
        init_mem();
        lat = 1;
        run_cmd("fwd_l1", 1'b0, 0, 32, 8, '0, 1);

        // overlapping copy, both latencies
        init_mem();
        lat = 3;
        run_cmd("ovl_l3", 1'b0, 4, 6, 8, '0, 2);
        init_mem();
        lat = 1;
        run_cmd("ovl_l1", 1'b0, 4, 6, 8, '0, 2);

        // dst below src overlapping: must stay forward
        run_cmd("ovl_lo", 1'b0, 20, 17, 6, '0, 1);

        // fill
        run_cmd("fill", 1'b1, 0, 10, 5, 32'hDEADBEEF, 1);

        // rejections and range edges
        run_cmd("rej_src", 1'b0, 60, 0, 5, '0, 0);
        run_cmd("rej_len0", 1'b0, 0, 8, 0, '0, 0);
        run_cmd("rej_dst", 1'b1, 0, 62, 3, 32'h1234, 0);
        run_cmd("edge_src", 1'b0, 56, 0, 8, '0, 1);
        run_cmd("edge_dst", 1'b1, 0, 60, 4, 32'hA5A5A5A5, 1);

        // reset in RD_WAIT during a copy
        init_mem();
        lat = 3;
        r0 = rd_cnt;
        @(negedge clk);
        start = 1'b1; fill = 1'b0; src_addr = 6'd0; dst_addr = 6'd40; len = 7'd8;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (rd_cnt < r0 + 2 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("rstmid.timeout", (n < 200), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
        @(negedge clk);
        chk("rstmid.busy_in_rst", busy, 0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        chk("rstmid.rd", rd_cnt - r0, 0);
        chk("rstmid.wr", wr_cnt - w0, 0);
        chk("rstmid.done", done_cnt - d0, 0);
        chk("rstmid.err", err_cnt - e0, 0);
        ref_mem[40] = ref_mem[0];  // the one word written before the abort
        chk_mem("rstmid.mem");
        run_cmd("after_rst", 1'b0, 8, 48, 4, '0, 1);

        // whole memory onto itself
        init_mem();
        lat = 1;
        run_cmd("full_l1", 1'b0, 0, 0, 64, '0, 1);
        lat = 3;
        run_cmd("full_l3", 1'b0, 0, 0, 64, '0, 1);

        // randomized commands against the memmove model
        init_mem();
        for (int it = 0; it < 30; it++) begin
            int s, d, l;
            logic f;
            lat = $urandom_range(1, 3);
            f = 1'($urandom_range(0, 1));
            s = $urandom_range(0, NW - 1);
            d = $urandom_range(0, NW - 1);
            l = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 64) : $urandom_range(1, 12);
            run_cmd($sformatf("rnd%0d", it), f, s, d, l, $urandom, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
